// File: rtl/lzrw1_group_packer_if.sv
// Item, flush and FIFO-write signals between the LZRW1 match stage, the
// group packer and the downstream byte FIFO.
interface lzrw1_group_packer_if #(
    parameter int FIFO_SIZE     = 128,
    parameter int MAX_BYTES_OUT = 16
);
    localparam int OCC_W = $clog2(FIFO_SIZE) + 1;
    localparam int NB_W  = $clog2(MAX_BYTES_OUT) + 1;

    logic                               item_valid;
    logic                               item_ready;
    logic                               item_is_copy;
    logic [7:0]                         item_literal;
    logic [11:0]                        item_offset;
    logic [4:0]                         item_length;
    logic                               flush_in;
    logic                               flush_done_out;
    logic [OCC_W-1:0]                   fifo_occupancy;
    logic [MAX_BYTES_OUT-1:0][7:0]      data_out;
    logic                               wr_en_out;
    logic [NB_W-1:0]                    num_bytes_out;
    logic                               busy_out;

    modport master (
        output item_valid, item_is_copy, item_literal, item_offset, item_length,
               flush_in, fifo_occupancy,
        input  item_ready, flush_done_out, data_out, wr_en_out, num_bytes_out, busy_out
    );

    modport slave (
        input  item_valid, item_is_copy, item_literal, item_offset, item_length,
               flush_in, fifo_occupancy,
        output item_ready, flush_done_out, data_out, wr_en_out, num_bytes_out, busy_out
    );
endinterface

// File: rtl/lzrw1_group_packer.sv
// Collects up to 16 LZRW1 items into a control-word-prefixed group and writes
// the group into the byte FIFO in chunks of up to MAX_BYTES_OUT bytes.
module lzrw1_group_packer #(
    parameter int FIFO_SIZE     = 128,
    parameter int MAX_BYTES_OUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    lzrw1_group_packer_if.slave   bus
);
    localparam int NB_W = $clog2(MAX_BYTES_OUT) + 1;

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t      state;
    logic [7:0]  gbuf [32];      // item bytes; the two control bytes are muxed in on emit
    logic [15:0] ctrl;
    logic [4:0]  item_count;
    logic [5:0]  item_bytes;
    logic [5:0]  ptr;
    logic        flush_pending;
    logic        flush_done;

    logic        accept;
    logic        flush_req;
    logic        can_write;
    logic        last_chunk;
    logic [4:0]  len_m3;
    int          total_bytes;
    int          remaining;
    int          chunk;
    int          room;

    assign bus.item_ready     = (state == COLLECT) && !reset;
    assign accept             = bus.item_valid && bus.item_ready;
    assign flush_req          = bus.flush_in || flush_pending;
    assign len_m3             = bus.item_length - 5'd3;
    assign bus.flush_done_out = flush_done;
    assign bus.busy_out       = (state == EMIT) || flush_pending;

    assign total_bytes = int'(item_bytes) + 2;
    assign remaining   = total_bytes - int'(ptr);
    assign chunk       = (remaining < MAX_BYTES_OUT) ? remaining : MAX_BYTES_OUT;
    assign room        = FIFO_SIZE - int'(bus.fifo_occupancy);
    // Writes are suppressed while reset is held so a reset during EMIT drops the group cleanly.
    assign can_write   = (state == EMIT) && !reset && (room >= chunk);
    assign last_chunk  = (int'(ptr) + chunk) == total_bytes;

    assign bus.wr_en_out     = can_write;
    assign bus.num_bytes_out = can_write ? NB_W'(chunk) : '0;

    always_comb begin
        bus.data_out = '0;
        for (int i = 0; i < MAX_BYTES_OUT; i++) begin
            int k;
            k = int'(ptr) + i;
            if (can_write && i < chunk) begin
                if (k == 0)      bus.data_out[i] = ctrl[7:0];
                else if (k == 1) bus.data_out[i] = ctrl[15:8];
                else             bus.data_out[i] = gbuf[5'(k - 2)];
            end
        end
    end

    // NOTE: the byte buffer has no reset; bytes past the current count are never
    // read, so clearing it would only add reset fan-out to a plain register file.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (bus.item_is_copy) begin
                gbuf[item_bytes[4:0]]        <= {bus.item_offset[11:8], len_m3[3:0]};
                gbuf[item_bytes[4:0] + 5'd1] <= bus.item_offset[7:0];
            end else begin
                gbuf[item_bytes[4:0]] <= bus.item_literal;
            end
        end
        if (accept && bus.item_is_copy)
            assert (bus.item_length >= 5'd3 && bus.item_length <= 5'd18);
    end

    // NOTE: every state register uses non-blocking assignment; later assignments in
    // the same branch (e.g. ptr cleared on the last chunk) deliberately override earlier ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= COLLECT;
            ctrl          <= '0;
            item_count    <= '0;
            item_bytes    <= '0;
            ptr           <= '0;
            flush_pending <= 1'b0;
            flush_done    <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        ctrl[item_count[3:0]] <= bus.item_is_copy;
                        item_count            <= item_count + 5'd1;
                        item_bytes            <= item_bytes + (bus.item_is_copy ? 6'd2 : 6'd1);
                    end
                    if ((accept && item_count == 5'd15) ||
                        (flush_req && (accept || item_count != 5'd0))) begin
                        state         <= EMIT;
                        ptr           <= '0;
                        flush_pending <= flush_req;
                    end else if (flush_req) begin
                        flush_done    <= 1'b1;
                        flush_pending <= 1'b0;
                    end
                end
                EMIT: begin
                    if (bus.flush_in)
                        flush_pending <= 1'b1;
                    if (can_write) begin
                        ptr <= ptr + 6'(chunk);
                        if (last_chunk) begin
                            state      <= COLLECT;
                            ctrl       <= '0;
                            item_count <= '0;
                            item_bytes <= '0;
                            ptr        <= '0;
                            if (flush_pending || bus.flush_in) begin
                                flush_done    <= 1'b1;
                                flush_pending <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_lzrw1_group_packer.sv
// Directed bench for lzrw1_group_packer: full literal/copy groups, flushes,
// FIFO back-pressure and reset during a stalled emit.
module tb_lzrw1_group_packer;
    localparam int FIFO_SIZE     = 128;
    localparam int MAX_BYTES_OUT = 16;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [15:0][7:0] exp_d;

    always #5 clk = ~clk;

    lzrw1_group_packer_if #(.FIFO_SIZE(FIFO_SIZE), .MAX_BYTES_OUT(MAX_BYTES_OUT)) bus ();

    lzrw1_group_packer #(.FIFO_SIZE(FIFO_SIZE), .MAX_BYTES_OUT(MAX_BYTES_OUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.item_valid   = 1'b0;
        bus.item_is_copy = 1'b0;
        bus.item_literal = 8'h00;
        bus.item_offset  = 12'h000;
        bus.item_length  = 5'd3;
        bus.flush_in     = 1'b0;
    endtask

    task automatic drive_lit(input logic [7:0] b);
        bus.item_valid   = 1'b1;
        bus.item_is_copy = 1'b0;
        bus.item_literal = b;
    endtask

    task automatic drive_copy(input logic [11:0] off, input logic [4:0] len);
        bus.item_valid   = 1'b1;
        bus.item_is_copy = 1'b1;
        bus.item_offset  = off;
        bus.item_length  = len;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr"},   128'(bus.wr_en_out), 128'(0));
        check({tag, "_num"},  128'(bus.num_bytes_out), 128'(0));
        check({tag, "_data"}, 128'(bus.data_out), 128'(0));
        check({tag, "_done"}, 128'(bus.flush_done_out), 128'(0));
        check({tag, "_busy"}, 128'(bus.busy_out), 128'(0));
    endtask

    initial begin
        idle();
        bus.fifo_occupancy = '0;
        reset = 1'b1;

        // reset
        step();
        check("rst_ready_low", 128'(bus.item_ready), 128'(0));
        step();
        reset = 1'b0;
        step();
        check("rst_ready_high", 128'(bus.item_ready), 128'(1));
        check_idle_outputs("rst");

        // 16 literals 0x00..0x0F, plus a flush arriving during EMIT
        for (int i = 0; i < 16; i++) begin
            drive_lit(8'(i));
            check("t1_ready", 128'(bus.item_ready), 128'(1));
            step();
        end
        idle();
        bus.flush_in = 1'b1;
        exp_d = '0;
        for (int j = 2; j < 16; j++) exp_d[j] = 8'(j - 2);
        check("t1_c0_wr",    128'(bus.wr_en_out), 128'(1));
        check("t1_c0_num",   128'(bus.num_bytes_out), 128'(16));
        check("t1_c0_data",  128'(bus.data_out), 128'(exp_d));
        check("t1_c0_ready", 128'(bus.item_ready), 128'(0));
        step();
        bus.flush_in = 1'b0;
        exp_d = '0;
        exp_d[0] = 8'h0E;
        exp_d[1] = 8'h0F;
        check("t1_c1_num",   128'(bus.num_bytes_out), 128'(2));
        check("t1_c1_data",  128'(bus.data_out), 128'(exp_d));
        check("t1_c1_ready", 128'(bus.item_ready), 128'(0));
        check("t1_c1_done",  128'(bus.flush_done_out), 128'(0));
        step();
        check("t1_ready_back", 128'(bus.item_ready), 128'(1));
        check("t1_done",       128'(bus.flush_done_out), 128'(1));
        check("t1_wr_off",     128'(bus.wr_en_out), 128'(0));
        check("t1_busy_off",   128'(bus.busy_out), 128'(0));
        step();
        check("t1_done_once",  128'(bus.flush_done_out), 128'(0));

        // 16 copies, offset 0xABC, length 18
        for (int i = 0; i < 16; i++) begin
            drive_copy(12'hABC, 5'd18);
            step();
        end
        idle();
        exp_d = '0;
        exp_d[0] = 8'hFF;
        exp_d[1] = 8'hFF;
        for (int j = 2; j < 16; j++) exp_d[j] = (j % 2 == 0) ? 8'hAF : 8'hBC;
        check("t2_c0_num",  128'(bus.num_bytes_out), 128'(16));
        check("t2_c0_data", 128'(bus.data_out), 128'(exp_d));
        step();
        for (int j = 0; j < 16; j++) exp_d[j] = (j % 2 == 0) ? 8'hAF : 8'hBC;
        check("t2_c1_num",  128'(bus.num_bytes_out), 128'(16));
        check("t2_c1_data", 128'(bus.data_out), 128'(exp_d));
        step();
        exp_d = '0;
        exp_d[0] = 8'hAF;
        exp_d[1] = 8'hBC;
        check("t2_c2_num",  128'(bus.num_bytes_out), 128'(2));
        check("t2_c2_data", 128'(bus.data_out), 128'(exp_d));
        step();
        check("t2_wr_off", 128'(bus.wr_en_out), 128'(0));
        check("t2_ready",  128'(bus.item_ready), 128'(1));
        check("t2_done",   128'(bus.flush_done_out), 128'(0));

        // literal, copy, literal, then flush
        drive_lit(8'h41);
        step();
        drive_copy(12'h005, 5'd3);
        step();
        drive_lit(8'h42);
        step();
        idle();
        bus.flush_in = 1'b1;
        check("t3_no_early_wr", 128'(bus.wr_en_out), 128'(0));
        step();
        bus.flush_in = 1'b0;
        exp_d = '0;
        exp_d[0] = 8'h02; exp_d[1] = 8'h00; exp_d[2] = 8'h41;
        exp_d[3] = 8'h00; exp_d[4] = 8'h05; exp_d[5] = 8'h42;
        check("t3_wr",   128'(bus.wr_en_out), 128'(1));
        check("t3_num",  128'(bus.num_bytes_out), 128'(6));
        check("t3_data", 128'(bus.data_out), 128'(exp_d));
        check("t3_busy", 128'(bus.busy_out), 128'(1));
        check("t3_done_early", 128'(bus.flush_done_out), 128'(0));
        step();
        check("t3_done",   128'(bus.flush_done_out), 128'(1));
        check("t3_wr_off", 128'(bus.wr_en_out), 128'(0));
        step();
        check("t3_done_once", 128'(bus.flush_done_out), 128'(0));

        // back-pressure: occupancy 120 blocks a 16-byte chunk, 112 admits it
        bus.fifo_occupancy = 8'd120;
        for (int i = 0; i < 16; i++) begin
            drive_lit(8'(8'h10 + i));
            step();
        end
        idle();
        check("t4_stall_wr",    128'(bus.wr_en_out), 128'(0));
        check("t4_stall_busy",  128'(bus.busy_out), 128'(1));
        check("t4_stall_ready", 128'(bus.item_ready), 128'(0));
        step();
        check("t4_stall2_wr",  128'(bus.wr_en_out), 128'(0));
        check("t4_stall2_num", 128'(bus.num_bytes_out), 128'(0));
        bus.fifo_occupancy = 8'd112;
        #1;
        exp_d = '0;
        for (int j = 2; j < 16; j++) exp_d[j] = 8'(8'h10 + j - 2);
        check("t4_go_wr",   128'(bus.wr_en_out), 128'(1));
        check("t4_go_num",  128'(bus.num_bytes_out), 128'(16));
        check("t4_go_data", 128'(bus.data_out), 128'(exp_d));
        step();
        exp_d = '0;
        exp_d[0] = 8'h1E;
        exp_d[1] = 8'h1F;
        check("t4_tail_num",  128'(bus.num_bytes_out), 128'(2));
        check("t4_tail_data", 128'(bus.data_out), 128'(exp_d));
        bus.fifo_occupancy = '0;
        step();
        check("t4_ready", 128'(bus.item_ready), 128'(1));

        // flush with an empty group
        bus.flush_in = 1'b1;
        check("t5_done_pre", 128'(bus.flush_done_out), 128'(0));
        step();
        bus.flush_in = 1'b0;
        check("t5_wr",   128'(bus.wr_en_out), 128'(0));
        check("t5_done", 128'(bus.flush_done_out), 128'(1));
        step();
        check("t5_done_once", 128'(bus.flush_done_out), 128'(0));
        check("t5_wr_after",  128'(bus.wr_en_out), 128'(0));

        // reset during a stalled EMIT
        bus.fifo_occupancy = 8'd120;
        for (int i = 0; i < 16; i++) begin
            drive_lit(8'(8'h60 + i));
            step();
        end
        idle();
        check("t6_stalled_wr",   128'(bus.wr_en_out), 128'(0));
        check("t6_stalled_busy", 128'(bus.busy_out), 128'(1));
        reset = 1'b1;
        step();
        check("t6_rst_ready", 128'(bus.item_ready), 128'(0));
        check_idle_outputs("t6_rst");
        bus.fifo_occupancy = '0;
        #1;
        check("t6_rst_nowr", 128'(bus.wr_en_out), 128'(0));
        reset = 1'b0;
        step();
        check("t6_ready", 128'(bus.item_ready), 128'(1));
        check("t6_idle_wr", 128'(bus.wr_en_out), 128'(0));
        drive_lit(8'h55);
        bus.flush_in = 1'b1;
        step();
        idle();
        exp_d = '0;
        exp_d[2] = 8'h55;
        check("t6_wr",   128'(bus.wr_en_out), 128'(1));
        check("t6_num",  128'(bus.num_bytes_out), 128'(3));
        check("t6_data", 128'(bus.data_out), 128'(exp_d));
        step();
        check("t6_done",   128'(bus.flush_done_out), 128'(1));
        check("t6_wr_off", 128'(bus.wr_en_out), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
